// File: rtl/keccak_round_ctrl.sv
// Keccak round controller: sequences absorb, keccak-f[1600] rounds and squeeze
// for SHAKE128/SHAKE256. Only enables and handshakes are produced here; the
// 1600-bit state and round logic live in a separate datapath.
module keccak_round_ctrl #(
   parameter int ROUNDS   = 24,
   parameter int RATE_128 = 1344,
   parameter int RATE_256 = 1088,
   parameter int SIZE_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        operation_mode,
   input  logic [SIZE_W-1:0] output_size,
   input  logic              input_buffer_ready,
   input  logic              last_block_in_buffer,
   input  logic              output_buffer_ready,
   output logic              input_buffer_ready_clr,
   output logic              last_block_in_buffer_clr,
   output logic              state_init,
   output logic              absorb_en,
   output logic              round_en,
   output logic [4:0]        round_idx,
   output logic              output_buffer_we,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERMUTE,
      SQUEEZE,
      DONE
   } state_t;

   localparam logic [4:0]        LAST_ROUND = 5'(ROUNDS - 1);
   localparam logic [SIZE_W-1:0] RATE128_W  = SIZE_W'(RATE_128);
   localparam logic [SIZE_W-1:0] RATE256_W  = SIZE_W'(RATE_256);

   state_t            state_q, state_d;
   logic [4:0]        round_cnt_q, round_cnt_d;
   logic [SIZE_W-1:0] remaining_q, remaining_d;
   logic [1:0]        mode_q, mode_d;
   logic              is_last_q, is_last_d;
   logic [SIZE_W-1:0] rate;

   // Only 2'b01 selects SHAKE256; every other encoding falls back to SHAKE128.
   always_comb begin
      rate = (mode_q == 2'b01) ? RATE256_W : RATE128_W;
   end

   // State register plus the round counter, remaining-bits counter and captured message attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         round_cnt_q <= '0;
         remaining_q <= '0;
         mode_q      <= '0;
         is_last_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_cnt_q <= round_cnt_d;
         remaining_q <= remaining_d;
         mode_q      <= mode_d;
         is_last_q   <= is_last_d;
      end
   end

   // Next-state and counter update; a block is only taken from IDLE or ABSORB, so a
   // block that arrives early waits in the external latch until the FSM is ready.
   always_comb begin
      state_d     = state_q;
      round_cnt_d = round_cnt_q;
      remaining_d = remaining_q;
      mode_d      = mode_q;
      is_last_d   = is_last_q;
      case (state_q)
         IDLE: begin
            if (input_buffer_ready) begin
               remaining_d = output_size;
               mode_d      = operation_mode;
               is_last_d   = last_block_in_buffer;
               round_cnt_d = '0;
               state_d     = PERMUTE;
            end
         end
         ABSORB: begin
            if (input_buffer_ready) begin
               is_last_d   = last_block_in_buffer;
               round_cnt_d = '0;
               state_d     = PERMUTE;
            end
         end
         PERMUTE: begin
            if (round_cnt_q == LAST_ROUND) begin
               round_cnt_d = '0;
               if (!is_last_q) begin
                  state_d = ABSORB;
               end else if (remaining_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = SQUEEZE;
               end
            end else begin
               round_cnt_d = round_cnt_q + 5'd1;
            end
         end
         SQUEEZE: begin
            if (output_buffer_ready) begin
               if (remaining_q <= rate) begin
                  remaining_d = '0;
                  state_d     = DONE;
               end else begin
                  remaining_d = remaining_q - rate;
                  state_d     = PERMUTE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control outputs decoded from the current state and the handshake inputs.
   always_comb begin
      input_buffer_ready_clr   = 1'b0;
      last_block_in_buffer_clr = 1'b0;
      state_init               = 1'b0;
      absorb_en                = 1'b0;
      round_en                 = 1'b0;
      round_idx                = '0;
      output_buffer_we         = 1'b0;
      busy                     = (state_q != IDLE);
      done                     = 1'b0;
      case (state_q)
         IDLE: begin
            if (input_buffer_ready) begin
               state_init               = 1'b1;
               absorb_en                = 1'b1;
               input_buffer_ready_clr   = 1'b1;
               last_block_in_buffer_clr = last_block_in_buffer;
            end
         end
         ABSORB: begin
            if (input_buffer_ready) begin
               absorb_en                = 1'b1;
               input_buffer_ready_clr   = 1'b1;
               last_block_in_buffer_clr = last_block_in_buffer;
            end
         end
         PERMUTE: begin
            round_en  = 1'b1;
            round_idx = round_cnt_q;
         end
         SQUEEZE: begin
            output_buffer_we = output_buffer_ready;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Testbench for keccak_round_ctrl: a latency vector table, hand-written corner
// sequences, and randomized messages compared against an event-trace model.
module tb_keccak_round_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  operation_mode;
   logic [31:0] output_size;
   logic        input_buffer_ready;
   logic        last_block_in_buffer;
   logic        output_buffer_ready;
   logic        input_buffer_ready_clr;
   logic        last_block_in_buffer_clr;
   logic        state_init;
   logic        absorb_en;
   logic        round_en;
   logic [4:0]  round_idx;
   logic        output_buffer_we;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rstV;
      logic        ibrV;
      logic        lbbV;
      logic        obrV;
      logic [1:0]  modeV;
      logic [31:0] sizeV;
      logic [12:0] expV;
   } vec_t;

   vec_t tbl[$];

   keccak_round_ctrl dut (
      .clk                      (clk),
      .rst                      (rst),
      .operation_mode           (operation_mode),
      .output_size              (output_size),
      .input_buffer_ready       (input_buffer_ready),
      .last_block_in_buffer     (last_block_in_buffer),
      .output_buffer_ready      (output_buffer_ready),
      .input_buffer_ready_clr   (input_buffer_ready_clr),
      .last_block_in_buffer_clr (last_block_in_buffer_clr),
      .state_init               (state_init),
      .absorb_en                (absorb_en),
      .round_en                 (round_en),
      .round_idx                (round_idx),
      .output_buffer_we         (output_buffer_we),
      .busy                     (busy),
      .done                     (done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Packs all control outputs into one vector in a fixed field order.
   function automatic logic [12:0] outVec();
      return {state_init, absorb_en, input_buffer_ready_clr, last_block_in_buffer_clr,
              round_en, round_idx, output_buffer_we, busy, done};
   endfunction

   function automatic logic [12:0] mk(bit si, bit ab, bit ic, bit lc, bit re,
                                      logic [4:0] idx, bit we, bit bu, bit dn);
      return {si, ab, ic, lc, re, idx, we, bu, dn};
   endfunction

   // Drives one cycle of inputs at the falling edge and lets combinational outputs settle.
   task automatic applyStimulus(input logic rstV, input logic ibrV, input logic lbbV,
                                input logic obrV, input logic [1:0] modeV,
                                input logic [31:0] sizeV);
      @(negedge clk);
      rst                  = rstV;
      input_buffer_ready   = ibrV;
      last_block_in_buffer = lbbV;
      output_buffer_ready  = obrV;
      operation_mode       = modeV;
      output_size          = sizeV;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Runs one message and compares the observed event trace with the trace derived from
   // block count, mode and length: per block one absorb and 24 rounds, then
   // ceil(size/rate) writes separated by 24-round permutations, then done.
   task automatic runMessage(input logic [1:0] mode, input int nblocks,
                             input logic [31:0] size, input bit rnd, input string name);
      int          expQ[$];
      int          obsQ[$];
      longint      rate;
      longint      nw;
      int          delivered;
      int          gap;
      int          cycles;
      bit          seenDone;
      bit          scramble;
      logic        ibrV;
      logic        lbbV;
      logic        obrV;
      logic [1:0]  curMode;
      logic [31:0] curSize;
      bit          same;

      rate = (mode == 2'b01) ? 1088 : 1344;
      for (int b = 0; b < nblocks; b++) begin
         expQ.push_back(100 + ((b == 0) ? 10 : 0) + ((b == nblocks - 1) ? 1 : 0));
         for (int r = 0; r < 24; r++) expQ.push_back(r);
      end
      if (size != 0) begin
         nw = (longint'(size) + rate - 1) / rate;
         for (longint w = 0; w < nw; w++) begin
            expQ.push_back(200);
            if (w < nw - 1) for (int r = 0; r < 24; r++) expQ.push_back(r);
         end
      end
      expQ.push_back(300);

      delivered = 0;
      gap       = rnd ? $urandom_range(0, 3) : 0;
      cycles    = 0;
      seenDone  = 0;
      scramble  = 0;
      ibrV      = 0;
      lbbV      = 0;
      curMode   = mode;
      curSize   = size;
      while (!seenDone && cycles < 4000) begin
         if (scramble) begin
            curMode = 2'($urandom);
            curSize = $urandom_range(0, 8000);
         end
         if (!ibrV && delivered < nblocks) begin
            if (gap == 0) begin
               ibrV = 1;
               lbbV = (delivered == nblocks - 1);
               delivered++;
               gap = rnd ? $urandom_range(0, 3) : 0;
            end else begin
               gap--;
            end
         end
         obrV = rnd ? (($urandom % 3) != 0) : 1'b1;
         applyStimulus(1'b0, ibrV, lbbV, obrV, curMode, curSize);
         if (absorb_en)
            obsQ.push_back(100 + (state_init ? 10 : 0) + (last_block_in_buffer_clr ? 1 : 0)
                           + (input_buffer_ready_clr ? 0 : 50));
         else begin
            if (input_buffer_ready_clr) obsQ.push_back(400);
            if (last_block_in_buffer_clr) obsQ.push_back(500);
         end
         if (round_en) obsQ.push_back(int'(round_idx));
         if (output_buffer_we) obsQ.push_back(200);
         if (done) begin
            obsQ.push_back(300);
            seenDone = 1;
         end
         if (absorb_en && rnd) scramble = 1;
         if (input_buffer_ready_clr) ibrV = 0;
         if (last_block_in_buffer_clr) lbbV = 0;
         cycles++;
      end
      checkOutput({name, "_done_seen"}, 32'(seenDone), 32'd1);

      same = (obsQ.size() == expQ.size());
      for (int i = 0; i < expQ.size() && same; i++) begin
         if (obsQ[i] != expQ[i]) begin
            same = 0;
            $display("[TB] trace %s differs at event %0d: got %0d want %0d", name, i, obsQ[i], expQ[i]);
         end
      end
      checks++;
      if (!same) begin
         failures++;
         $display("[TB] FAIL %s_trace actual_events=%0d required_events=%0d", name, obsQ.size(), expQ.size());
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
      checkOutput({name, "_idle_after"}, 32'(outVec()), 32'd0);
   endtask

   initial begin
      rst                  = 1'b1;
      input_buffer_ready   = 1'b0;
      last_block_in_buffer = 1'b0;
      output_buffer_ready  = 1'b0;
      operation_mode       = 2'b00;
      output_size          = 32'd0;

      // Single SHAKE128 block, 256 output bits: absorb at T, rounds T+1..T+24,
      // write at T+25, done at T+26, idle at T+27.
      begin
         vec_t v;
         v = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'd256, mk(0,0,0,0,0,5'd0,0,0,0)};
         tbl.push_back(v);
         v.rstV = 1'b0;
         tbl.push_back(v);
         v = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'd256, mk(1,1,1,1,0,5'd0,0,0,0)};
         tbl.push_back(v);
         for (int i = 0; i < 24; i++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd256, mk(0,0,0,0,1,5'(i),0,1,0)};
            tbl.push_back(v);
         end
         v = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd256, mk(0,0,0,0,0,5'd0,1,1,0)};
         tbl.push_back(v);
         v = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd256, mk(0,0,0,0,0,5'd0,0,1,1)};
         tbl.push_back(v);
         v = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd256, mk(0,0,0,0,0,5'd0,0,0,0)};
         tbl.push_back(v);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].rstV, tbl[i].ibrV, tbl[i].lbbV, tbl[i].obrV, tbl[i].modeV, tbl[i].sizeV);
         checkOutput($sformatf("vec%0d", i), 32'(outVec()), 32'(tbl[i].expV));
      end

      // Reset while round 10 is being applied, then a zero-length last block.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'd512);
      checkOutput("rst_absorb", 32'(outVec()), 32'(mk(1,1,1,0,0,5'd0,0,0,0)));
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd512);
         checkOutput($sformatf("rst_round%0d", k), 32'(outVec()), 32'(mk(0,0,0,0,1,5'(k),0,1,0)));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'd512);
      checkOutput("rst_mid_idx", 32'(round_idx), 32'd10);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd512);
      checkOutput("after_rst", 32'(outVec()), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'd0);
      checkOutput("post_rst_init", 32'(outVec()), 32'(mk(1,1,1,1,0,5'd0,0,0,0)));
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0);
         checkOutput($sformatf("size0_round%0d", k), 32'(outVec()), 32'(mk(0,0,0,0,1,5'(k),0,1,0)));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0);
      checkOutput("size0_done", 32'(outVec()), 32'(mk(0,0,0,0,0,5'd0,0,1,1)));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0);
      checkOutput("size0_idle", 32'(outVec()), 32'd0);

      // Output buffer stalled for 5 cycles; an early block waits in the latch until IDLE.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'd256);
      checkOutput("stall_absorb", 32'(outVec()), 32'(mk(1,1,1,1,0,5'd0,0,0,0)));
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1'b0, (k >= 5), 1'b0, 1'b0, 2'b00, 32'd256);
         checkOutput($sformatf("stall_round%0d", k), 32'(outVec()), 32'(mk(0,0,0,0,1,5'(k),0,1,0)));
      end
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd256);
         checkOutput($sformatf("stall_wait%0d", k), 32'(outVec()), 32'(mk(0,0,0,0,0,5'd0,0,1,0)));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'd256);
      checkOutput("stall_write", 32'(outVec()), 32'(mk(0,0,0,0,0,5'd0,1,1,0)));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'd256);
      checkOutput("stall_done", 32'(outVec()), 32'(mk(0,0,0,0,0,5'd0,0,1,1)));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'd256);
      checkOutput("stall_late_block", 32'(outVec()), 32'(mk(1,1,1,0,0,5'd0,0,0,0)));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
      checkOutput("stall_cleanup", 32'(outVec()), 32'd0);

      // Directed multi-block / multi-write messages, then randomized messages.
      runMessage(2'b00, 1, 32'd3000, 1'b0, "shake128_3000");
      runMessage(2'b01, 3, 32'd512,  1'b0, "shake256_3blk");
      runMessage(2'b10, 1, 32'd1344, 1'b0, "mode2_rate_exact");
      runMessage(2'b01, 2, 32'd1089, 1'b0, "shake256_rate_plus1");
      for (int m = 0; m < 30; m++) begin
         logic [1:0]  md;
         logic [31:0] sz;
         int          nb;
         md = 2'($urandom);
         nb = $urandom_range(1, 3);
         sz = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
         runMessage(md, nb, sz, 1'b1, $sformatf("rand%0d", m));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
- Central sequencer for the permute pipeline stage. Runs absorb, keccak-f[1600] rounds and squeeze for SHAKE128/SHAKE256.
- Consumes the input-buffer/last-block flags set by the load stage and clears them when done with them.
- Gates output-buffer writes against the requested output length.
- Drives state/round enables only; the round datapath lives elsewhere.

Parameters:
- ROUNDS, 24, number of keccak-f rounds per permutation.
- RATE_128, 1344, SHAKE128 rate in bits.
- RATE_256, 1088, SHAKE256 rate in bits.
- SIZE_W, 32, width of output_size and of the remaining-bits counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- operation_mode  in  2  2'b00 SHAKE128, 2'b01 SHAKE256; 2'b1x treated as SHAKE128.
- output_size  in  SIZE_W  requested squeeze length in bits; sampled on the first absorb.
- input_buffer_ready  in  1  rate block available (latched flag).
- last_block_in_buffer  in  1  current block is the final padded block.
- output_buffer_ready  in  1  output buffer can take one rate block.
- input_buffer_ready_clr  out  1  one-cycle clear of the input-ready latch.
- last_block_in_buffer_clr  out  1  one-cycle clear of the last-block latch.
- state_init  out  1  zero the 1600-bit state before XOR (first block only).
- absorb_en  out  1  XOR rate input into the state this cycle.
- round_en  out  1  apply one round this cycle.
- round_idx  out  5  round constant index, 0..ROUNDS-1.
- output_buffer_we  out  1  write the rate portion of the state to the output buffer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of message.

Behaviour:
- All control outputs are combinational from state and inputs.
- All state, counters and captured values are registered.
- Reset (synchronous, priority over everything, including mid-permutation):
  - FSM returns to IDLE; round_cnt=0; remaining=0; mode_q=0; is_last_q=0.
  - All outputs are 0.
  - Datapath state is not cleared by this block; the next message asserts state_init.
- IDLE:
  - On input_buffer_ready=1, in the same cycle assert state_init, absorb_en and input_buffer_ready_clr.
  - Same cycle: capture output_size into remaining and operation_mode into mode_q.
  - Same cycle: capture last_block_in_buffer into is_last_q; if it is 1, also assert last_block_in_buffer_clr.
  - Next state: PERMUTE.
- ABSORB (waiting for the next block):
  - On input_buffer_ready=1, do the same as IDLE except state_init=0 and no capture of size/mode.
  - Next state: PERMUTE.
  - input_buffer_ready=0: hold; all outputs 0.
- PERMUTE:
  - round_en=1 and round_idx=round_cnt every cycle; round_cnt increments.
  - At round_cnt=ROUNDS-1, round_cnt wraps to 0 and the next state depends on is_last_q and remaining:
    - is_last_q=0 goes to ABSORB.
    - is_last_q=1 and remaining=0 goes to DONE.
    - Otherwise goes to SQUEEZE.
  - Exactly ROUNDS cycles per permutation; no early exit.
- SQUEEZE:
  - Wait while output_buffer_ready=0, with output_buffer_we=0.
  - When output_buffer_ready=1, assert output_buffer_we for one cycle.
  - Same cycle, with rate = RATE_128 or RATE_256 per mode_q:
    - remaining <= rate: remaining becomes 0, next state DONE.
    - Otherwise remaining decreases by rate and the next state is PERMUTE (squeeze permutation).
  - A final partial block is written whole; the downstream stage truncates.
- DONE: done=1 for one cycle, then IDLE.
- input_buffer_ready asserted in PERMUTE, SQUEEZE or DONE is ignored. The latch holds it, and it is consumed only from IDLE or ABSORB.
- Latency, single block with 1 ≤ output_size ≤ rate and output_buffer_ready held high:
  - Absorb at cycle T.
  - Rounds at T+1..T+24.
  - Write at T+25.
  - done at T+26.
  - busy low from T+27.
- The remaining counter never underflows; subtraction is unsigned and saturating by construction.

Test Plan:
- Reset in mid-PERMUTE (round_idx=10) → next cycle: all outputs 0, busy=0. A following block asserts state_init=1.
- SHAKE128, one last block, output_size=256, output_buffer_ready=1 → the checks below hold:
  - absorb_en, state_init and both clears at T.
  - round_idx 0..23 at T+1..T+24.
  - output_buffer_we at T+25.
  - done at T+26.
- SHAKE256, three blocks (last on the third), output_size=512 → the checks below hold:
  - Three absorb_en pulses, each followed by 24 round_en cycles.
  - state_init only on the first pulse; exactly one output_buffer_we.
- SHAKE128, output_size=3000 → three writes: remaining 3000→1656→312→0, with 24-cycle permutations between writes.
- output_size=0 with last block → no output_buffer_we; done one cycle after round 23.
- output_buffer_ready held 0 for 5 cycles in SQUEEZE → output_buffer_we stays 0, then exactly one write; input_buffer_ready pulsed during PERMUTE is not consumed until IDLE.
